// File: rtl/multi_edge_stretcher_pkg.sv
// Shared definitions for the multi-channel edge stretcher: edge-select
// encodings, default parameters, channel state type and legality helpers.
package multi_edge_stretcher_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STRETCH     = 125000000;
    localparam int DEF_CNT_W       = 27;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ch_state_t;

    // True when a cnt_w-bit down-counter can hold the reload value stretch-1.
    function automatic bit cnt_fits(input int stretch, input int cnt_w);
        longint lim;
        if (cnt_w >= 62) return 1'b1;
        lim = longint'(1) << cnt_w;
        return lim > (longint'(stretch) - 1);
    endfunction

    function automatic logic edge_qualify(input logic [1:0] mode, input logic rise,
                                          input logic fall);
        logic q;
        case (mode)
            EDGE_RISE: q = rise;
            EDGE_FALL: q = fall;
            EDGE_BOTH: q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_stretch_ch.sv
// One channel: synchroniser, edge qualification, stretch counter and sticky
// missed-edge flag. o_state is the IDLE/ACTIVE flop and doubles as the output.
module edge_stretch_ch
    import multi_edge_stretcher_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STRETCH     = DEF_STRETCH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RETRIG      = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_inp,
    input  logic [1:0] i_mode,
    input  logic       i_clr_missed,
    output logic       o_edge_pulse,
    output logic       o_missed,
    output logic       o_state
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    ch_state_t              r_state;
    ch_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_edge_pulse;
    logic                   w_edge_pulse_nxt;
    logic                   r_missed;
    logic                   w_missed_nxt;
    logic                   w_s_last;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;

    assign w_s_last = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_s_last & ~r_prev;
    assign w_fall   = ~w_s_last & r_prev;
    assign w_edge   = edge_qualify(i_mode, w_rise, w_fall);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_inp};
            r_prev <= w_s_last;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_edge_pulse <= 1'b0;
            r_missed     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_edge_pulse <= w_edge_pulse_nxt;
            r_missed     <= w_missed_nxt;
        end
    end

    // A miss on the same cycle as clr_missed overrides the clear.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_edge_pulse_nxt = 1'b0;
        w_missed_nxt     = r_missed & ~i_clr_missed;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_nxt      = ST_ACTIVE;
                    w_cnt_nxt        = RELOAD;
                    w_edge_pulse_nxt = 1'b1;
                end
            end
            ST_ACTIVE: begin
                w_edge_pulse_nxt = w_edge;
                if (w_edge && (RETRIG != 0)) begin
                    w_cnt_nxt = RELOAD;
                end else begin
                    if (w_edge) w_missed_nxt = 1'b1;
                    if (r_cnt == '0) w_state_nxt = ST_IDLE;
                    else             w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_edge_pulse = r_edge_pulse;
    assign o_missed     = r_missed;
    assign o_state      = r_state;

endmodule

// File: rtl/multi_edge_stretcher.sv
// N_CH independent edge-detect-and-stretch channels with a shared busy flag.
// Parameter legality is enforced at elaboration.
module multi_edge_stretcher
    import multi_edge_stretcher_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STRETCH     = DEF_STRETCH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RETRIG      = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] inp,
    input  logic [1:0]      mode,
    input  logic            clr_missed,
    output logic [N_CH-1:0] edge_pulse,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] missed,
    output logic            busy
);

    if (N_CH < 1) begin : g_bad_n_ch
        $fatal(1, "multi_edge_stretcher: N_CH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "multi_edge_stretcher: SYNC_STAGES must be >= 2");
    end
    if (STRETCH < 1) begin : g_bad_stretch
        $fatal(1, "multi_edge_stretcher: STRETCH must be >= 1");
    end
    if (!cnt_fits(STRETCH, CNT_W)) begin : g_bad_cnt_w
        $fatal(1, "multi_edge_stretcher: CNT_W too small for STRETCH-1");
    end
    if (RETRIG != 0 && RETRIG != 1) begin : g_bad_retrig
        $fatal(1, "multi_edge_stretcher: RETRIG must be 0 or 1");
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        edge_stretch_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .STRETCH    (STRETCH),
            .CNT_W      (CNT_W),
            .RETRIG     (RETRIG)
        ) u_ch (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_inp       (inp[g]),
            .i_mode      (mode),
            .i_clr_missed(clr_missed),
            .o_edge_pulse(edge_pulse[g]),
            .o_missed    (missed[g]),
            .o_state     (out[g])
        );
    end

    assign busy = |out;

endmodule
